imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader for the writable instruction memory.
- Takes a byte stream from a UART/debug host over a valid/ready handshake and packs bytes little-endian into Dbits-wide instructions.
- Drives the memory write port at sequential addresses starting at 0, and holds the CPU stalled until the load completes or is aborted.

Parameters:
- Nloc, 64, number of instruction memory locations.
- Dbits, 32, instruction width in bits. Must be a multiple of 8. BYTES = Dbits/8, derived.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- num_words  input  $clog2(Nloc)+1  words to load; sampled together with start.
- abort  input  1  cancel the load in progress.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr  output  1  memory write enable.
- waddr  output  $clog2(Nloc)  memory write address.
- wdata  output  Dbits  memory write data.
- cpu_hold  output  1  stall/hold CPU fetch.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse on successful completion.
- words_loaded  output  $clog2(Nloc)+1  words written in the current or last load.

Behaviour:
- States: IDLE, COLLECT, WRITE, FINISH.
- Reset values: state=IDLE; byte_ready=0, wr=0, waddr=0, wdata=0, cpu_hold=0, busy=0, done=0, words_loaded=0. Byte index and assembly register are cleared.
- Reset mid-load: returns to IDLE the next cycle with no done pulse. The partial word is discarded. Memory words already written stay written.
- IDLE + start:
  - target = min(num_words, Nloc); words_loaded=0; waddr=0.
  - If target==0, go to FINISH; otherwise go to COLLECT.
  - start in any other state is ignored.
- COLLECT:
  - byte_ready=1.
  - On byte_valid&&byte_ready, byte_data is stored in wdata[8k+7:8k], where k is the byte index (0 first, little-endian), and k increments.
  - After byte BYTES-1 is accepted, go to WRITE and reset k to 0.
  - No byte is accepted while byte_valid=0.
- WRITE:
  - Lasts exactly one cycle: wr=1, waddr=current address, wdata=assembled word; byte_ready=0.
  - Next cycle: words_loaded+1 and waddr+1.
  - If the new words_loaded==target, go to FINISH; else go to COLLECT.
  - waddr does not wrap in practice, because target<=Nloc stops the load first.
- FINISH: done=1 for exactly one cycle, then IDLE.
- cpu_hold = busy = (state != IDLE). Both are combinational from state, so they are high from the cycle after start is sampled through FINISH inclusive.
- wr is only ever high in WRITE.
- abort:
  - In COLLECT or WRITE, abort forces IDLE on the next edge with no done pulse.
  - If abort coincides with WRITE, the write still occurs that cycle, and words_loaded counts it.
  - abort has priority over byte acceptance: no byte is consumed in a cycle where abort=1.
  - abort in IDLE or FINISH has no effect (done still pulses).
- Simultaneous start and abort in IDLE: start wins, because abort is ignored in IDLE.
- Throughput with byte_valid held high (cycle 0 = start sampled):
  - Bytes are accepted in cycles 1..BYTES, and WRITE falls in cycle BYTES+1.
  - Each word takes BYTES+1 cycles.
  - For N words with Dbits=32, the last WRITE is in cycle 5N, done in cycle 5N+1, and IDLE is reached in cycle 5N+2.
- words_loaded holds its final value in IDLE until the next start.

Test Plan:
- Single word: start with num_words=1, then bytes 0x13,0x00,0x40,0x20 back-to-back -> wr=1 at cycle 5 with waddr=0 and wdata=0x20400013; done=1 at cycle 6; words_loaded=1; cpu_hold high cycles 1-6, low at 7.
- Three words with byte_valid idle for 2 cycles between every byte -> byte_ready stays 1 through the gaps; writes go to waddr 0,1,2 with the correct little-endian words; exactly three wr pulses; done pulses once.
- num_words=0 -> done at cycle 1; no wr; no byte accepted; words_loaded=0.
- num_words=100 with Nloc=64 -> exactly 64 writes to addresses 0..63, then done; words_loaded=64; byte 257 is not accepted (byte_ready=0 after the load).
- abort after 2 bytes of word 1 (word 0 already written) -> IDLE next cycle, no done, words_loaded=1, no further wr. A new start then reloads from waddr=0.
- Reset asserted during COLLECT, plus start pulsed while busy -> reset clears all outputs to their reset values on the next edge. The in-flight start is ignored; the load proceeds with the original target.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port used by imem_loader.
// master: the loader side (accepts bytes, drives the memory write port).
// slave:  the host/memory side (supplies bytes, observes writes).
interface imem_loader_if #(
    parameter int Nloc  = 64,
    parameter int Dbits = 32
);
    localparam int AW = $clog2(Nloc);

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             wr;
    logic [AW-1:0]    waddr;
    logic [Dbits-1:0] wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, wr, waddr, wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, wr, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a little-endian byte stream into
// Dbits-wide words, writes them at ascending addresses from 0 and holds the CPU
// until the load finishes or is aborted.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for start; words_loaded holds the last result
//  COLLECT | accepting bytes into the assembly register
//  WRITE   | one-cycle memory write of the assembled word
//  FINISH  | one-cycle done pulse, then back to IDLE
module imem_loader #(
    parameter int Nloc  = 64,
    parameter int Dbits = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [$clog2(Nloc):0] num_words,
    input  logic                  abort,
    imem_loader_if.master         bus,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [$clog2(Nloc):0] words_loaded
);
    localparam int AW    = $clog2(Nloc);
    localparam int BYTES = Dbits / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BW-1:0] K_LAST = BW'(BYTES - 1);
    localparam logic [AW:0]   NLOC_W = (AW + 1)'(Nloc);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t           state, next_state;
    logic [AW:0]      target;
    logic [AW:0]      target_in;
    logic [AW:0]      words_q;
    logic [AW:0]      words_inc;
    logic [AW-1:0]    waddr_q;
    logic [Dbits-1:0] wdata_q;
    logic [BW-1:0]    k;
    logic             byte_ready_c;
    logic             wr_c;
    logic             done_c;
    logic             accept;

    // Requests beyond the memory size are clamped so the address never wraps.
    assign target_in = (num_words > NLOC_W) ? NLOC_W : num_words;
    assign words_inc = words_q + 1'b1;
    assign accept    = byte_ready_c && bus.byte_valid;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-state outputs; abort gates byte_ready so no byte is
    // consumed in the cycle the load is cancelled.
    always_comb begin
        next_state   = state;
        byte_ready_c = 1'b0;
        wr_c         = 1'b0;
        done_c       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (target_in == '0) ? S_FINISH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready_c = !abort;
                if (abort) begin
                    next_state = S_IDLE;
                end else if (bus.byte_valid && (k == K_LAST)) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_c = 1'b1;
                if (abort) begin
                    next_state = S_IDLE;
                end else if (words_inc == target) begin
                    next_state = S_FINISH;
                end else begin
                    next_state = S_COLLECT;
                end
            end
            S_FINISH: begin
                done_c     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: target capture, byte assembly, address and word count.
    // The write in an aborted WRITE cycle still lands, so it is still counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            target  <= '0;
            words_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            k       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target  <= target_in;
                        words_q <= '0;
                        waddr_q <= '0;
                        k       <= '0;
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        k <= '0;
                    end else if (accept) begin
                        for (int i = 0; i < BYTES; i++) begin
                            if (k == BW'(i)) begin
                                wdata_q[8*i +: 8] <= bus.byte_data;
                            end
                        end
                        k <= (k == K_LAST) ? '0 : k + 1'b1;
                    end
                end
                S_WRITE: begin
                    words_q <= words_inc;
                    waddr_q <= waddr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_c;
    assign bus.wr         = wr_c;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign done           = done_c;
    assign busy           = (state != S_IDLE);
    assign cpu_hold       = (state != S_IDLE);
    assign words_loaded   = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a table of directed loads, randomized
// loads against a word-level reference model, and a reset-during-load sequence.
module tb_imem_loader;
    localparam int NLOC = 64;
    localparam int DB   = 32;
    localparam int BY   = DB / 8;
    localparam int SLEN = 300;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] num_words;
    logic       abort;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [6:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream [SLEN];
    logic [31:0] last_wdata;

    typedef struct {
        int nw;
        int gap;
        int abort_at;
        bit pulse;
        int exp_words;
        bit exp_done;
        int exp_bytes;
    } vec_t;

    vec_t vecs [8];

    imem_loader_if #(.Nloc(NLOC), .Dbits(DB)) bus ();

    imem_loader #(.Nloc(NLOC), .Dbits(DB)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_words    (num_words),
        .abort        (abort),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word-level reference: clamp to memory size; an abort raised after A
    // accepted bytes (A up to the full stream) leaves floor(A/BY) words written.
    function automatic vec_t model(input int nw, input int gap, input int a, input bit pulse);
        vec_t v;
        int   tgt;
        tgt        = (nw > NLOC) ? NLOC : nw;
        v.nw       = nw;
        v.gap      = gap;
        v.abort_at = a;
        v.pulse    = pulse;
        if (a >= 0 && tgt > 0 && a <= tgt * BY) begin
            v.exp_words = a / BY;
            v.exp_done  = 1'b0;
            v.exp_bytes = a;
        end else begin
            v.exp_words = tgt;
            v.exp_done  = 1'b1;
            v.exp_bytes = tgt * BY;
        end
        return v;
    endfunction

    // Runs one load from IDLE; called #1 after a posedge.
    task automatic run_load(input string tag, input vec_t v);
        int          cyc, acc, gapc, ndone, done_cyc, idle_cyc;
        int          hold_bad, abort_acc, bad, post_bad, tgt;
        bit          abort_sent, hit;
        logic [5:0]  wa_q [$];
        logic [31:0] wd_q [$];
        logic [31:0] expw;
        logic [6:0]  wl_end;
        tgt = (v.nw > NLOC) ? NLOC : v.nw;
        start = 1'b1;
        num_words = 7'(v.nw);
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1; acc = 0; gapc = 0; ndone = 0; done_cyc = -1; idle_cyc = -1;
        hold_bad = 0; abort_acc = 0; abort_sent = 1'b0;
        while (cyc < 3000) begin
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            bus.byte_valid = (gapc == 0) && (acc < SLEN);
            bus.byte_data  = stream[acc % SLEN];
            abort = 1'b0;
            if (v.abort_at >= 0 && !abort_sent && acc == v.abort_at) begin
                abort = 1'b1;
                abort_sent = 1'b1;
            end
            if (v.pulse && cyc == 2) begin
                start = 1'b1;
                num_words = 7'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (cpu_hold !== busy) hold_bad++;
            if (bus.wr) begin
                wa_q.push_back(bus.waddr);
                wd_q.push_back(bus.wdata);
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            hit = bus.byte_valid && bus.byte_ready;
            if (hit) begin
                if (abort) abort_acc++;
                acc++;
            end
            @(posedge clock); #1;
            if (hit) gapc = v.gap;
            else if (gapc > 0) gapc--;
            cyc++;
        end
        bus.byte_valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        if (idle_cyc < 0) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_words_loaded"}, words_loaded, v.exp_words);
        chk({tag, "_done_pulses"}, ndone, v.exp_done ? 1 : 0);
        chk({tag, "_bytes_accepted"}, acc, v.exp_bytes);
        chk({tag, "_wr_count"}, wa_q.size(), v.exp_words);
        chk({tag, "_hold_vs_busy"}, hold_bad, 0);
        chk({tag, "_accept_during_abort"}, abort_acc, 0);
        bad = 0;
        for (int w = 0; w < wa_q.size(); w++) begin
            expw = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
            if (wa_q[w] !== 6'(w) || wd_q[w] !== expw) begin
                bad++;
                $display("FAIL %s_write[%0d]: addr %0d data 0x%08h expected addr %0d data 0x%08h",
                         tag, w, wa_q[w], wd_q[w], w, expw);
            end
        end
        chk({tag, "_write_contents"}, bad, 0);
        if (wd_q.size() > 0) last_wdata = wd_q[wd_q.size()-1];
        if (v.gap == 0 && v.exp_done && !v.pulse) begin
            chk({tag, "_done_cycle"}, done_cyc, (BY + 1) * tgt + 1);
            chk({tag, "_idle_cycle"}, idle_cyc, (BY + 1) * tgt + 2);
        end
        // After the load, offered bytes must be refused and the count held.
        wl_end = words_loaded;
        post_bad = 0;
        bus.byte_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (bus.byte_ready || bus.wr || done || busy) post_bad++;
            @(posedge clock); #1;
        end
        bus.byte_valid = 1'b0;
        chk({tag, "_quiet_after_load"}, post_bad, 0);
        chk({tag, "_words_loaded_held"}, words_loaded, wl_end);
        if (idle_cyc < 0) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
        end
    endtask

    task automatic fill_stream();
        for (int j = 0; j < SLEN; j++) stream[j] = 8'($urandom);
    endtask

    initial begin
        int   nw, gap, a, tgt, quiet_bad;
        vec_t rv;
        reset = 1'b1;
        start = 1'b0;
        num_words = '0;
        abort = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = '0;
        last_wdata = '0;

        vecs[0] = '{1,   0, -1, 1'b0, 1,  1'b1, 4};
        vecs[1] = '{3,   2, -1, 1'b0, 3,  1'b1, 12};
        vecs[2] = '{0,   0, -1, 1'b0, 0,  1'b1, 0};
        vecs[3] = '{100, 0, -1, 1'b0, 64, 1'b1, 256};
        vecs[4] = '{2,   0, 6,  1'b0, 1,  1'b0, 6};
        vecs[5] = '{2,   1, 4,  1'b0, 1,  1'b0, 4};
        vecs[6] = '{3,   0, -1, 1'b1, 3,  1'b1, 12};
        vecs[7] = '{5,   3, 0,  1'b0, 0,  1'b0, 0};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_byte_ready", bus.byte_ready, 0);
        chk("rst_wr", bus.wr, 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_words_loaded", words_loaded, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 8; i++) begin
            fill_stream();
            if (i == 0) begin
                stream[0] = 8'h13;
                stream[1] = 8'h00;
                stream[2] = 8'h40;
                stream[3] = 8'h20;
            end
            run_load($sformatf("vec%0d", i), vecs[i]);
            if (i == 0) chk("single_word_value", last_wdata, 32'h20400013);
        end

        // Reset in the middle of word 1: everything clears, nothing more happens.
        fill_stream();
        start = 1'b1;
        num_words = 7'd3;
        @(posedge clock); #1;
        start = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'hA5;
        repeat (7) begin
            @(posedge clock); #1;
        end
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_cpu_hold", cpu_hold, 0);
        chk("midrst_byte_ready", bus.byte_ready, 0);
        chk("midrst_wr", bus.wr, 0);
        chk("midrst_waddr", bus.waddr, 0);
        chk("midrst_wdata", bus.wdata, 0);
        chk("midrst_words_loaded", words_loaded, 0);
        quiet_bad = 0;
        repeat (6) begin
            @(negedge clock);
            if (done || bus.wr || bus.byte_ready) quiet_bad++;
            @(posedge clock); #1;
        end
        bus.byte_valid = 1'b0;
        chk("midrst_quiet", quiet_bad, 0);
        run_load("after_reset", model(2, 0, -1, 1'b0));

        // Randomized loads checked against the word-level model.
        for (int r = 0; r < 16; r++) begin
            fill_stream();
            nw  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(60, 127)) : int'($urandom_range(0, 6));
            gap = int'($urandom_range(0, 3));
            tgt = (nw > NLOC) ? NLOC : nw;
            a   = -1;
            if ($urandom_range(0, 2) == 0 && tgt > 0) a = int'($urandom_range(0, tgt * BY));
            rv = model(nw, gap, a, $urandom_range(0, 3) == 0);
            run_load($sformatf("rand%0d", r), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
